// File: rtl/pc_state_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_state_reg
// Purpose  : Y86-64 architectural PC, run/halt control, stat code and
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_state_reg #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          COUNT_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [63:0]        PC_update,
  input  logic [3:0]         icode,
  input  logic               imem_error,
  input  logic               dmem_error,
  output logic [63:0]        PC,
  output logic [2:0]         stat,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] C_STAT_AOK = 3'd1;
  localparam logic [2:0] C_STAT_HLT = 3'd2;
  localparam logic [2:0] C_STAT_ADR = 3'd3;
  localparam logic [2:0] C_STAT_INS = 3'd4;
  localparam logic [3:0] C_ICODE_HALT = 4'h0;
  localparam logic [3:0] C_ICODE_MAX  = 4'hB;

  state_t               state_q, state_d;
  logic [63:0]          pc_q, pc_d;
  logic [2:0]           stat_q, stat_d;
  logic [COUNT_W-1:0]   icount_q, icount_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    icount_d = icount_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          // Fault checks are ordered; the first match wins.
          if (imem_error) begin
            stat_d  = C_STAT_ADR;
            state_d = ST_HALT;
          end else if (icode > C_ICODE_MAX) begin
            stat_d  = C_STAT_INS;
            state_d = ST_HALT;
          end else if (dmem_error) begin
            stat_d  = C_STAT_ADR;
            state_d = ST_HALT;
          end else if (icode == C_ICODE_HALT) begin
            stat_d   = C_STAT_HLT;
            state_d  = ST_HALT;
            icount_d = icount_q + COUNT_W'(1);
          end else begin
            pc_d     = PC_update;
            icount_d = icount_q + COUNT_W'(1);
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unused encoding falls back to idle.
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      stat_q    <= C_STAT_AOK;
      icount_q  <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      icount_q  <= icount_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign PC      = pc_q;
  assign stat    = stat_q;
  assign running = running_q;
  assign halted  = halted_q;
  assign icount  = icount_q;

endmodule
`default_nettype wire

// File: doc/pc_state_reg.md
# pc_state_reg

Architectural PC and processor-status register for the Y86-64 sequential datapath, sitting directly downstream of the PC-update stage and upstream of fetch. Each retiring cycle it latches the next-PC value from PC update into `PC`, which fetch uses for the next instruction. It also runs the top-level run/halt state machine: it decides from the current instruction's `icode` and the memory error flags whether the PC advances or the machine stops. It maintains the Y86 `stat` code and a retired-instruction counter.

## Interface
- `RESET_PC`, 64'h0, PC value loaded on reset
- `COUNT_W`, 64, width of retired-instruction counter
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  level/pulse; leaves IDLE when sampled high
- `stall`  in  1  freeze: no state, PC, stat or count change this edge
- `PC_update`  in  64  next PC from PC-update stage
- `icode`  in  4  icode of instruction at current `PC`
- `imem_error`  in  1  fetch address invalid for current instruction
- `dmem_error`  in  1  data-memory address invalid for current instruction
- `PC`  out  64  current architectural PC
- `stat`  out  3  Y86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- `running`  out  1  high while in RUN
- `halted`  out  1  high while in HALT
- `icount`  out  COUNT_W  retired-instruction count

## Operation
- States: IDLE, RUN, HALT. Encoding is free. `running`/`halted` decode from the state register only.
- Reset (`rst_n`=0, any time): state=IDLE, `PC`=RESET_PC, `stat`=1 (AOK), `icount`=0, `running`=0, `halted`=0.
- IDLE: `start`=1 moves to RUN. No PC/stat/count change. `stall`, `icode` and error inputs are ignored.
- RUN, `stall`=1: hold everything. Error inputs are ignored this edge.
- RUN, `stall`=0: the current instruction retires or faults. Checks are evaluated in this priority order:
  - `imem_error`=1: `stat`=3 (ADR), go to HALT. PC unchanged, count unchanged.
  - `icode` > 4'hB: `stat`=4 (INS), go to HALT. PC unchanged, count unchanged.
  - `dmem_error`=1: `stat`=3 (ADR), go to HALT. PC unchanged, count unchanged.
  - `icode`=4'h0 (halt): `stat`=2 (HLT), go to HALT. PC unchanged, `icount`+1.
  - Otherwise: `PC`<=`PC_update`, `icount`+1, `stat` stays 1, remain in RUN.
- HALT: terminal state. `start`, `stall` and all data inputs are ignored. Only `rst_n` exits, returning to IDLE.
- `start` while in RUN or HALT has no effect.
- `icount` wraps modulo 2^COUNT_W with no saturation and no flag.
- After a fault or halt, `PC` points at the offending or halt instruction.

## Timing
- All outputs are registered. None depends combinationally on inputs.
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- `PC_update`, `icode` and the error flags must be stable before the rising edge. They are computed combinationally from the current `PC` within the same cycle.
- `start` sampled in IDLE gives `running`=1 after that edge. The first retirement can occur on the following edge.
- Fault edge: `stat`, `halted`=1 and `running`=0 all change on the same edge.
- `rst_n` assertion clears state immediately, without waiting for a clock edge. Deassertion is synchronous to the next edge: the first edge after release sees the block in IDLE.

## Test plan
- **Reset/idle.** Hold `rst_n`=0, then release with `start`=0 for 5 cycles, `PC_update`=64'h40, `icode`=4'h1. Required: `PC`=0, `stat`=1, `icount`=0, `running`=0 throughout.
- **Normal run.** Pulse `start`, then present 3 retiring cycles with `icode`=4'h3 and `PC_update`=10, 20, 30. Required: `PC` reads 10, 20, 30 on successive cycles, then `icount`=3 and `stat`=1.
- **Stall and halt.** In RUN, hold `stall`=1 for 2 cycles with `icode`=4'hC and `imem_error`=1. Required: no change. Then set `stall`=0, `icode`=4'h0, errors low. Required: `stat`=2, `halted`=1, `PC` unchanged, `icount` incremented by 1. A further `start` does nothing.
- **Fault priority.** In RUN with `PC`=64'h100, apply `imem_error`=1, `dmem_error`=1, `icode`=4'hF together. Required: `stat`=3, `PC`=64'h100, `icount` unchanged. In a separate run, apply `icode`=4'hC with `dmem_error`=1. Required: `stat`=4.
- **Counter wrap.** Use COUNT_W=4 and retire 17 instructions. Required: `icount`=1 and no stat change.
- **Reset mid-operation.** Assert `rst_n` low between edges while in RUN with `PC`=64'h58. Required: outputs return to their reset values before the next edge. After release, the block stays in IDLE until `start`.
